// File: rtl/reg_enc_pkg.sv
// Shared constants, types and helpers for the register-mask encoder.
// REG_ENC_COUNT_EN (optional) enables the popcount helper's use in the top level.
package reg_enc_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef logic [NUM_REGS-1:0] mask_t;

    function automatic logic [ADDR_W:0] popcount16(input mask_t m);
        logic [ADDR_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            n = n + {{ADDR_W{1'b0}}, m[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Lowest-set-bit encoder: inverse of the register bank's 4-to-16 decoder.
// Index reads 0 when no bit is set; any_o distinguishes that from bit 0.
module prio_enc16
    import reg_enc_pkg::*;
(
    input  logic [NUM_REGS-1:0] vec_i,
    output logic [ADDR_W-1:0]   idx_o,
    output logic                any_o
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ADDR_W'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/reg_mask_encoder.sv
// Serializes a 16-bit register write mask into ascending 4-bit addresses.
// Define REG_ENC_COUNT_EN to add the count port (popcount of the captured mask).
module reg_mask_encoder
    import reg_enc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] req_mask,
    input  logic                req_valid,
    output logic                req_ready,
    output logic [ADDR_W-1:0]   dest,
    output logic                dest_valid,
    input  logic                dest_ready,
`ifdef REG_ENC_COUNT_EN
    output logic                done,
    output logic [ADDR_W:0]     count
`else
    output logic                done
`endif
);

    state_t            state_q;
    mask_t             pending_q;
    mask_t             pending_d;
    logic [ADDR_W-1:0] enc_idx;
    logic              enc_any;

    prio_enc16 u_prio_enc16 (
        .vec_i (pending_q),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // Handshake: a beat transfers when dest_valid && dest_ready at a rising edge.
    // dest/dest_valid depend only on registered state, never on dest_ready.
    assign req_ready  = (state_q == IDLE);
    assign dest_valid = (state_q == DRAIN) && enc_any;
    assign done       = (state_q == DRAIN) && !enc_any;
    assign dest       = dest_valid ? enc_idx : '0;

    always_comb begin
        pending_d = pending_q;
        if (dest_valid && dest_ready) begin
            pending_d = pending_q & ~(mask_t'(1) << enc_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        pending_q <= req_mask;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!enc_any) begin
                        state_q <= IDLE;
                    end else begin
                        pending_q <= pending_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef REG_ENC_COUNT_EN
    logic [ADDR_W:0] count_q;

    // Held until the next accept; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (state_q == IDLE && req_valid) begin
            count_q <= popcount16(req_mask);
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Directed bench for reg_mask_encoder; define REG_ENC_COUNT_EN to also check count.
module tb_reg_mask_encoder;

    logic        clk;
    logic        reset;
    logic [15:0] req_mask;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  dest;
    logic        dest_valid;
    logic        dest_ready;
    logic        done;
`ifdef REG_ENC_COUNT_EN
    logic [4:0]  count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    reg_mask_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .req_mask   (req_mask),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .dest       (dest),
        .dest_valid (dest_valid),
        .dest_ready (dest_ready),
`ifdef REG_ENC_COUNT_EN
        .done       (done),
        .count      (count)
`else
        .done       (done)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string tag, input logic [4:0] exp);
`ifdef REG_ENC_COUNT_EN
        chk(tag, 32'(count), 32'(exp));
`else
        if (exp > 5'd16) $display("note: %s count %0d out of range", tag, exp);
`endif
    endtask

    // Accept a mask with dest_ready held high and check every beat, done and return to IDLE.
    task automatic drain_check(input logic [15:0] m, input string tag);
        logic [3:0] e;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (m[i]) exp_q.push_back(4'(i));
        end
        chk({tag, "_accept_ready"}, 32'(req_ready), 32'd1);
        req_mask   = m;
        req_valid  = 1'b1;
        dest_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk_count({tag, "_count"}, 5'($countones(m)));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_beat_valid"}, 32'(dest_valid), 32'd1);
            chk({tag, "_beat_dest"}, 32'(dest), 32'(e));
            chk({tag, "_beat_nodone"}, 32'(done), 32'd0);
            chk({tag, "_beat_busy"}, 32'(req_ready), 32'd0);
            tick();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_novalid"}, 32'(dest_valid), 32'd0);
        chk({tag, "_done_dest0"}, 32'(dest), 32'd0);
        chk_count({tag, "_done_count"}, 5'($countones(m)));
        tick();
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_idle_nodone"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_mask   = '0;
        req_valid  = 1'b0;
        dest_ready = 1'b0;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_dest_valid", 32'(dest_valid), 32'd0);
        chk("rst_dest", 32'(dest), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_count("rst_count", 5'd0);
        tick();
        reset = 1'b0;

        drain_check(16'h8421, "m8421");
        drain_check(16'h0000, "m0000");
        drain_check(16'hFFFF, "mFFFF");

        // Stall on dest=8 for 3 cycles, with a stray request pulsed mid-drain.
        req_mask   = 16'h0300;
        req_valid  = 1'b1;
        dest_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", 32'(dest_valid), 32'd1);
            chk("stall_dest8", 32'(dest), 32'd8);
            if (c == 1) begin
                req_mask  = 16'h00F0;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        req_valid  = 1'b0;
        dest_ready = 1'b1;
        chk("stall_release_dest8", 32'(dest), 32'd8);
        chk("stall_release_valid", 32'(dest_valid), 32'd1);
        tick();
        chk("stall_dest9", 32'(dest), 32'd9);
        chk("stall_dest9_valid", 32'(dest_valid), 32'd1);
        tick();
        chk("stall_done", 32'(done), 32'd1);
        chk_count("stall_count", 5'd2);
        tick();
        chk("stall_idle_ready", 32'(req_ready), 32'd1);
        tick();
        chk("stall_no_queued_req", 32'(dest_valid), 32'd0);
        chk("stall_still_idle", 32'(req_ready), 32'd1);

        // Reset in the middle of draining 16'hFFFF after 3 beats.
        req_mask   = 16'hFFFF;
        req_valid  = 1'b1;
        dest_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk("mid_beat", 32'(dest), 32'(b));
            tick();
        end
        chk("mid_pre_reset_dest3", 32'(dest), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_dest_valid", 32'(dest_valid), 32'd0);
        chk("mid_rst_dest", 32'(dest), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk_count("mid_rst_count", 5'd0);
        tick();
        reset = 1'b0;
        drain_check(16'h0001, "post_rst");

        for (int i = 0; i < 16; i++) begin
            logic [15:0] oh;
            oh = 16'h0001 << i;
            drain_check(oh, $sformatf("onehot%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
